// File: rtl/pengo_input_if.sv
// ============================================================================
// Module      : pengo_input_if
// Description : Input-side bus of the pengo input stage (PS/2, joystick, IN0/IN1).
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface pengo_input_if;
    logic [10:0] ps2_key;
    logic [15:0] joy;
    logic        horz;
    logic [7:0]  in0;
    logic [7:0]  in1;
    logic [1:0]  coin_busy;

    modport master (
        output ps2_key, joy, horz,
        input  in0, in1, coin_busy
    );

    modport slave (
        input  ps2_key, joy, horz,
        output in0, in1, coin_busy
    );
endinterface

`default_nettype wire

// File: rtl/pengo_input_ctrl.sv
// ============================================================================
// Module      : pengo_input_ctrl
// Description : PS/2 + joystick merge, Horz remap and coin pulse shaping for
//               the pengo IN0/IN1 ports. Macro KEYB_P2_EN adds P2 keyboard keys.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pengo_input_ctrl #(
    parameter int COIN_PULSE = 2400000,
    parameter int COIN_GAP   = 1200000,
    parameter int CNT_W      = 22
) (
    input  wire            clk_sys,
    input  wire            reset_n,
    pengo_input_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(COIN_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(COIN_GAP - 1);

    wire       key_tgl     = bus.ps2_key[10];
    wire       key_pressed = bus.ps2_key[9];
    wire       key_ext     = bus.ps2_key[8];
    wire [7:0] key_code    = bus.ps2_key[7:0];
    wire       unused_joy  = ^bus.joy[15:7];

    logic old_tgl;
    logic key_up, key_down, key_left, key_right, key_fire1;
    logic key_f1, key_f2, key_1, key_2, key_5, key_6;
`ifdef KEYB_P2_EN
    logic key_up2, key_down2, key_left2, key_right2, key_fire2;
`endif

    wire key_evt = key_tgl != old_tgl;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            old_tgl    <= 1'b0;
            key_up     <= 1'b0;
            key_down   <= 1'b0;
            key_left   <= 1'b0;
            key_right  <= 1'b0;
            key_fire1  <= 1'b0;
            key_f1     <= 1'b0;
            key_f2     <= 1'b0;
            key_1      <= 1'b0;
            key_2      <= 1'b0;
            key_5      <= 1'b0;
            key_6      <= 1'b0;
`ifdef KEYB_P2_EN
            key_up2    <= 1'b0;
            key_down2  <= 1'b0;
            key_left2  <= 1'b0;
            key_right2 <= 1'b0;
            key_fire2  <= 1'b0;
`endif
        end else begin
            old_tgl <= key_tgl;
            if (key_evt) begin
                // Arrow keys arrive with or without the E0 prefix; everything else must be unextended
                case (key_code)
                    8'h75: key_up    <= key_pressed;
                    8'h72: key_down  <= key_pressed;
                    8'h6B: key_left  <= key_pressed;
                    8'h74: key_right <= key_pressed;
                    default: begin
                        if (!key_ext) begin
                            case (key_code)
                                8'h29, 8'h14: key_fire1 <= key_pressed;
                                8'h05: key_f1 <= key_pressed;
                                8'h06: key_f2 <= key_pressed;
                                8'h16: key_1  <= key_pressed;
                                8'h1E: key_2  <= key_pressed;
                                8'h2E: key_5  <= key_pressed;
                                8'h36: key_6  <= key_pressed;
`ifdef KEYB_P2_EN
                                8'h2D: key_up2    <= key_pressed;
                                8'h2B: key_down2  <= key_pressed;
                                8'h23: key_left2  <= key_pressed;
                                8'h34: key_right2 <= key_pressed;
                                8'h1C: key_fire2  <= key_pressed;
`endif
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    // Direction nibble is {right,left,down,up}; rotation sends up->left, left->down, down->right, right->up
    function automatic logic [3:0] remap(input logic [3:0] d, input logic rot);
        return rot ? {d[1], d[0], d[2], d[3]} : d;
    endfunction

    logic [3:0] joy_dir;
    logic [3:0] dir1, dir2;
    logic       start1, start2, fire1, fire2;
    logic [1:0] coin_src;
    logic [1:0] coin_act;
    logic [1:0] coin_busy_vec;

    always_comb begin
        joy_dir = {bus.joy[0], bus.joy[1], bus.joy[2], bus.joy[3]};
        dir1    = remap({key_right, key_left, key_down, key_up} | joy_dir, bus.horz);
`ifdef KEYB_P2_EN
        dir2    = remap({key_right2, key_left2, key_down2, key_up2} | joy_dir, bus.horz);
        fire2   = key_fire2;
`else
        dir2    = remap(joy_dir, bus.horz);
        fire2   = 1'b0;
`endif
        start1      = key_f1 | key_1 | bus.joy[5];
        start2      = key_f2 | key_2 | bus.joy[6];
        fire1       = key_fire1 | bus.joy[4];
        coin_src[0] = key_5;
        coin_src[1] = key_6 | start1 | start2;
    end

    for (genvar s = 0; s < 2; s++) begin : g_slot
        logic [1:0]       state, state_nx;
        logic [CNT_W-1:0] cnt;
        logic             src_d;
        logic             act, busy;

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                state <= ST_IDLE;
                src_d <= 1'b0;
            end else begin
                state <= state_nx;
                src_d <= coin_src[s];
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
            end else if (state_nx != state) begin
                cnt <= '0;
            end else if (state == ST_PULSE || state == ST_GAP) begin
                cnt <= cnt + 1'b1;
            end
        end

        always_comb begin
            state_nx = state;
            case (state)
                ST_IDLE:  if (coin_src[s] && !src_d) state_nx = ST_PULSE;
                ST_PULSE: if (cnt == PULSE_LAST)     state_nx = ST_GAP;
                ST_GAP:   if (cnt == GAP_LAST)       state_nx = ST_WAIT;
                ST_WAIT:  if (!coin_src[s])          state_nx = ST_IDLE;
                default:                             state_nx = ST_IDLE;
            endcase
        end

        always_comb begin
            act  = (state == ST_PULSE);
            busy = (state != ST_IDLE);
        end

        assign coin_act[s]      = act;
        assign coin_busy_vec[s] = busy;
    end

    logic [7:0] in0_reg, in1_reg;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            in0_reg <= 8'hFF;
            in1_reg <= 8'hFF;
        end else begin
            in0_reg <= ~{fire1, 1'b0, coin_act[0], coin_act[1], dir1};
            in1_reg <= ~{fire2, start2, start1, 1'b0, dir2};
        end
    end

    assign bus.in0       = in0_reg;
    assign bus.in1       = in1_reg;
    assign bus.coin_busy = coin_busy_vec;

endmodule

`default_nettype wire
